// File: rtl/board_player_mover.sv
// Board-game player sprite mover: accepts dice moves and hops the player tile by
// tile, one animation step per video frame, tracking the current tile and laps.
module board_player_mover #(
    parameter int START_X     = 16,
    parameter int BASE_Y      = 124,
    parameter int TILE_W      = 32,
    parameter int NUM_TILES   = 16,
    parameter int HOP_FRAMES  = 16,
    parameter int X_STEP      = 2,
    parameter int LIFT_STEP   = 2,
    parameter int REST_FRAMES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic                         move_valid,
    input  logic [2:0]                   move_steps,
    output logic                         move_ready,
    output logic [9:0]                   player_x,
    output logic [9:0]                   player_y,
    output logic [$clog2(NUM_TILES)-1:0] tile_idx,
    output logic                         busy,
    output logic                         move_done,
    output logic                         lap_pulse,
    output logic [7:0]                   lap_count,
    output logic                         invalid_move
);

    localparam int TW = $clog2(NUM_TILES);
    localparam int HW = $clog2(HOP_FRAMES + 1);
    localparam int RW = $clog2(REST_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOP, S_REST} state_t;

    state_t        r_state,       w_state_nxt;
    logic [HW-1:0] r_hop_frame,   w_hop_frame_nxt;
    logic [RW-1:0] r_rest_cnt,    w_rest_cnt_nxt;
    logic [2:0]    r_steps_left,  w_steps_left_nxt;
    logic [TW-1:0] r_tile,        w_tile_nxt;
    logic [9:0]    r_x,           w_x_nxt;
    logic [9:0]    r_y,           w_y_nxt;
    logic [7:0]    r_lap_count,   w_lap_count_nxt;
    logic          r_ready,       w_ready_nxt;
    logic          r_busy,        w_busy_nxt;
    logic          r_done,        w_done_nxt;
    logic          r_lap,         w_lap_nxt;
    logic          r_invalid,     w_invalid_nxt;

    logic [HW-1:0] w_hf_inc;
    logic [HW-1:0] w_hf_rem;
    logic [HW-1:0] w_hf_min;
    logic [9:0]    w_lift;
    logic [9:0]    w_tile_x;
    logic [TW-1:0] w_tile_inc;
    logic [9:0]    w_land_x;
    logic [RW-1:0] w_rest_inc;
    logic          w_wrap;
    logic          w_land;
    logic          w_steps_legal;

    // Hop triangle: lift rises for the first half of the hop and falls for the second.
    assign w_hf_inc      = r_hop_frame + 1'b1;
    assign w_hf_rem      = HW'(HOP_FRAMES) - w_hf_inc;
    assign w_hf_min      = (w_hf_inc < w_hf_rem) ? w_hf_inc : w_hf_rem;
    assign w_lift        = 10'(LIFT_STEP) * 10'(w_hf_min);
    assign w_tile_x      = 10'(START_X) + 10'(TILE_W) * 10'(r_tile);
    assign w_tile_inc    = r_tile + 1'b1;
    assign w_land_x      = 10'(START_X) + 10'(TILE_W) * 10'(w_tile_inc);
    assign w_rest_inc    = r_rest_cnt + 1'b1;
    assign w_wrap        = (r_tile == TW'(NUM_TILES - 1));
    assign w_land        = (w_hf_inc == HW'(HOP_FRAMES));
    assign w_steps_legal = (move_steps != 3'd0) && (move_steps != 3'd7);

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt      = r_state;
        w_hop_frame_nxt  = r_hop_frame;
        w_rest_cnt_nxt   = r_rest_cnt;
        w_steps_left_nxt = r_steps_left;
        w_tile_nxt       = r_tile;
        w_x_nxt          = r_x;
        w_y_nxt          = r_y;
        w_lap_count_nxt  = r_lap_count;
        w_ready_nxt      = r_ready;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_lap_nxt        = 1'b0;
        w_invalid_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                if (move_valid && r_ready) begin
                    if (w_steps_legal) begin
                        w_steps_left_nxt = move_steps;
                        w_hop_frame_nxt  = '0;
                        w_state_nxt      = S_HOP;
                        w_busy_nxt       = 1'b1;
                        w_ready_nxt      = 1'b0;
                    end else begin
                        w_invalid_nxt = 1'b1;
                    end
                end
            end
            S_HOP: begin
                if (frame_tick) begin
                    if (w_land) begin
                        w_tile_nxt       = w_tile_inc;
                        w_x_nxt          = w_land_x;
                        w_y_nxt          = 10'(BASE_Y);
                        w_hop_frame_nxt  = '0;
                        w_steps_left_nxt = r_steps_left - 1'b1;
                        if (w_wrap) begin
                            w_lap_nxt       = 1'b1;
                            w_lap_count_nxt = r_lap_count + 1'b1;
                        end
                        if (r_steps_left == 3'd1) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                            w_ready_nxt = 1'b1;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_state_nxt    = S_REST;
                            w_rest_cnt_nxt = '0;
                        end
                    end else begin
                        w_hop_frame_nxt = w_hf_inc;
                        w_y_nxt         = 10'(BASE_Y) - w_lift;
                        // The wrap hop from the last tile keeps x still; landing snaps it to tile 0.
                        if (!w_wrap) w_x_nxt = w_tile_x + 10'(X_STEP) * 10'(w_hf_inc);
                    end
                end
            end
            S_REST: begin
                if (frame_tick) begin
                    if (w_rest_inc == RW'(REST_FRAMES)) begin
                        w_state_nxt     = S_HOP;
                        w_hop_frame_nxt = '0;
                        w_rest_cnt_nxt  = '0;
                    end else begin
                        w_rest_cnt_nxt = w_rest_inc;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_hop_frame  <= '0;
            r_rest_cnt   <= '0;
            r_steps_left <= '0;
            r_tile       <= '0;
            r_x          <= 10'(START_X);
            r_y          <= 10'(BASE_Y);
            r_lap_count  <= '0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_lap        <= 1'b0;
            r_invalid    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hop_frame  <= w_hop_frame_nxt;
            r_rest_cnt   <= w_rest_cnt_nxt;
            r_steps_left <= w_steps_left_nxt;
            r_tile       <= w_tile_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_lap_count  <= w_lap_count_nxt;
            r_ready      <= w_ready_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_lap        <= w_lap_nxt;
            r_invalid    <= w_invalid_nxt;
        end
    end

    assign move_ready   = r_ready;
    assign player_x     = r_x;
    assign player_y     = r_y;
    assign tile_idx     = r_tile;
    assign busy         = r_busy;
    assign move_done    = r_done;
    assign lap_pulse    = r_lap;
    assign lap_count    = r_lap_count;
    assign invalid_move = r_invalid;

endmodule

// File: tb/tb_board_player_mover.sv
// Scoreboard bench for board_player_mover: a tick-level position model and an
// event model feed queues that an independent monitor drains and compares.
module tb_board_player_mover;

    localparam int START_X     = 16;
    localparam int BASE_Y      = 124;
    localparam int TILE_W      = 32;
    localparam int NUM_TILES   = 16;
    localparam int HOP_FRAMES  = 16;
    localparam int X_STEP      = 2;
    localparam int LIFT_STEP   = 2;
    localparam int REST_FRAMES = 4;
    localparam int PERIOD      = HOP_FRAMES + REST_FRAMES;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       move_valid;
    logic [2:0] move_steps;
    logic       move_ready;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [3:0] tile_idx;
    logic       busy;
    logic       move_done;
    logic       lap_pulse;
    logic [7:0] lap_count;
    logic       invalid_move;

    board_player_mover dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .move_valid   (move_valid),
        .move_steps   (move_steps),
        .move_ready   (move_ready),
        .player_x     (player_x),
        .player_y     (player_y),
        .tile_idx     (tile_idx),
        .busy         (busy),
        .move_done    (move_done),
        .lap_pulse    (lap_pulse),
        .lap_count    (lap_count),
        .invalid_move (invalid_move)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_LAP, EV_DONE, EV_INV} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       tile;
        int       x;
        int       laps;
        int       ticks;
    } ev_t;
    typedef struct {
        int x;
        int y;
        int tile;
        int busy;
    } tr_t;

    ev_t ev_q[$];
    tr_t tr_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference model state: a move is the pair (start tile, step count) plus ticks elapsed.
    int  m_tile = 0, m_laps = 0, m_start = 0, m_n = 0, m_k = 0, m_total = 0;
    bit  m_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int tx(input int t);
        return START_X + TILE_W * t;
    endfunction

    function automatic tr_t exp_pos();
        tr_t r;
        int  h, p, t, m;
        r.busy = m_active ? 1 : 0;
        if (!m_active || m_k == 0) begin
            t = m_active ? m_start : m_tile;
            r.tile = t; r.x = tx(t); r.y = BASE_Y;
            return r;
        end
        h = (m_k - 1) / PERIOD;
        p = m_k - h * PERIOD;
        if (p >= HOP_FRAMES) begin
            t = (m_start + h + 1) % NUM_TILES;
            r.tile = t; r.x = tx(t); r.y = BASE_Y;
        end else begin
            t = (m_start + h) % NUM_TILES;
            m = (p < HOP_FRAMES - p) ? p : HOP_FRAMES - p;
            r.tile = t;
            r.y = BASE_Y - LIFT_STEP * m;
            r.x = (t == NUM_TILES - 1) ? tx(t) : tx(t) + X_STEP * p;
        end
        return r;
    endfunction

    task automatic model(input bit tick, input bit valid, input logic [2:0] steps);
        ev_t e;
        int  laps;
        if (!m_active && valid) begin
            if (steps >= 3'd1 && steps <= 3'd6) begin
                m_active = 1'b1; m_start = m_tile; m_n = int'(steps); m_k = 0;
                m_total = m_n * HOP_FRAMES + (m_n - 1) * REST_FRAMES;
                laps = m_laps;
                for (int j = 1; j <= m_n; j++) begin
                    if ((m_start + j) % NUM_TILES == 0) begin
                        laps = (laps + 1) % 256;
                        e = '{EV_LAP, 0, START_X, laps, 0};
                        ev_q.push_back(e);
                    end
                end
                e = '{EV_DONE, (m_start + m_n) % NUM_TILES, tx((m_start + m_n) % NUM_TILES), laps, m_total};
                ev_q.push_back(e);
            end else begin
                e = '{EV_INV, m_tile, tx(m_tile), m_laps, 0};
                ev_q.push_back(e);
            end
        end else if (m_active && tick) begin
            m_k++;
            if (m_k == m_total) begin
                m_active = 1'b0;
                m_laps   = (m_laps + (m_start + m_n) / NUM_TILES) % 256;
                m_tile   = (m_start + m_n) % NUM_TILES;
            end
        end
        if (tick) tr_q.push_back(exp_pos());
    endtask

    // One clock cycle of stimulus, driven from the falling edge.
    task automatic cyc(input bit tick, input bit valid, input logic [2:0] steps);
        frame_tick = tick;
        move_valid = valid;
        move_steps = steps;
        model(tick, valid, steps);
        @(negedge clk);
    endtask

    task automatic run_move(input logic [2:0] steps, input bit tick_on_accept, input bit stray);
        cyc(tick_on_accept, 1'b1, steps);
        for (int guard = 0; guard < 2000 && m_active; guard++)
            cyc(guard % 2 == 1, stray && (guard % 7 == 3), 3'($urandom_range(0, 7)));
        cyc(1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 3'd0);
    endtask

    // Monitor: compares the DUT against the queues whenever it presents a tick result or a pulse.
    logic tick_seen = 1'b0;
    always @(posedge clk) tick_seen <= frame_tick;

    initial begin
        tr_t t;
        ev_t e;
        int  busy_ticks = 0;
        bit  b_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_ticks = 0;
                b_last = 1'b0;
            end else begin
                if (tick_seen && b_last) busy_ticks++;
                b_last = busy;
                if (tick_seen) begin
                    if (tr_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL trace_underflow: got tick result, expected none queued");
                    end else begin
                        t = tr_q.pop_front();
                        check("trace_x", player_x, t.x);
                        check("trace_y", player_y, t.y);
                        check("trace_tile", tile_idx, t.tile);
                        check("trace_busy", busy, t.busy);
                    end
                end
                if (lap_pulse || move_done || invalid_move) begin
                    if (lap_pulse) begin
                        e = (ev_q.size() > 0) ? ev_q.pop_front() : '{EV_INV, -1, -1, -1, -1};
                        check("lap_kind", e.kind, EV_LAP);
                        check("lap_count", lap_count, e.laps);
                    end
                    if (move_done) begin
                        e = (ev_q.size() > 0) ? ev_q.pop_front() : '{EV_INV, -1, -1, -1, -1};
                        check("done_kind", e.kind, EV_DONE);
                        check("done_tile", tile_idx, e.tile);
                        check("done_x", player_x, e.x);
                        check("done_y", player_y, BASE_Y);
                        check("done_laps", lap_count, e.laps);
                        check("done_busy_ticks", busy_ticks, e.ticks);
                        check("done_ready", move_ready, 1);
                        busy_ticks = 0;
                    end
                    if (invalid_move) begin
                        e = (ev_q.size() > 0) ? ev_q.pop_front() : '{EV_DONE, -1, -1, -1, -1};
                        check("inv_kind", e.kind, EV_INV);
                        check("inv_tile", tile_idx, e.tile);
                        check("inv_x", player_x, e.x);
                        check("inv_busy", busy, 0);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; move_valid = 1'b0; move_steps = 3'd0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_x", player_x, START_X);
        check("rst_y", player_y, BASE_Y);
        check("rst_tile", tile_idx, 0);
        check("rst_ready", move_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pulses", {move_done, lap_pulse, invalid_move}, 0);
        check("rst_laps", lap_count, 0);

        run_move(3'd1, 1'b0, 1'b0);            // tile 0 -> 1
        run_move(3'd3, 1'b0, 1'b0);            // 1 -> 4
        run_move(3'd6, 1'b0, 1'b1);            // 4 -> 10, stray requests while busy
        run_move(3'd4, 1'b1, 1'b0);            // 10 -> 14, tick on the accept cycle
        run_move(3'd2, 1'b0, 1'b0);            // 14 -> 0 with a lap
        run_move(3'd0, 1'b0, 1'b0);
        run_move(3'd7, 1'b0, 1'b0);

        // Abort a move part way through its first hop.
        cyc(1'b0, 1'b1, 3'd3);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 3'd0);
            cyc(1'b0, 1'b0, 3'd0);
        end
        check("pre_rst_busy", busy, 1);
        frame_tick = 1'b0; move_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_x", player_x, START_X);
        check("mid_rst_y", player_y, BASE_Y);
        check("mid_rst_tile", tile_idx, 0);
        check("mid_rst_laps", lap_count, 0);
        check("mid_rst_busy", busy, 0);
        ev_q.delete();
        m_active = 1'b0; m_tile = 0; m_laps = 0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int mv = 0; mv < 40; mv++) begin
            cyc($urandom_range(0, 1) == 1, 1'b1, 3'($urandom_range(0, 7)));
            for (int guard = 0; guard < 3000 && m_active; guard++)
                cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)));
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                cyc($urandom_range(0, 1) == 1, 1'b0, 3'd0);
        end

        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 3'd0);
        check("end_busy", busy, 0);
        check("end_events_left", ev_q.size(), 0);
        check("end_trace_left", tr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
